// File: rtl/mdsa_pkg.sv
// Shared definitions for the multidimensional sorter (MDSA) matrix path.
// Lane count, sort directions, controller states and result tags.
package mdsa_pkg;

    localparam int LANES  = 8;
    localparam int PASSES = 2 * $clog2(LANES) + 1;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        DRAIN,
        UNLOAD
    } state_t;

    typedef struct packed {
        logic       v;
        logic [2:0] l;
    } tag_t;

endpackage

// File: rtl/mdsa_line_mux.sv
// Row or column select of the 8x8 matrix feeding the sorter.
// col_sel=0 picks row idx, col_sel=1 picks column idx.
module mdsa_line_mux
    import mdsa_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]       m [LANES][LANES],
    input  logic                col_sel,
    input  logic [2:0]          idx,
    output logic [LANES*DW-1:0] line
);

    always_comb begin
        line = '0;
        for (int k = 0; k < LANES; k++) begin
            line[k*DW +: DW] = col_sel ? m[k][idx] : m[idx][k];
        end
    end

endmodule

// File: rtl/mdsa_shear_ctrl.sv
// Shear-sort controller: loads an 8x8 block, runs 7 row/column passes
// through the external sorter, then unloads the matrix in snake order.
module mdsa_shear_ctrl
    import mdsa_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_LINES    = 8,
    parameter int SORT_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_LINES*DATA_WIDTH-1:0] in_row,
    output logic                          sort_en,
    output logic                          sort_dir,
    output logic [N_LINES*DATA_WIDTH-1:0] sort_line,
    input  logic [N_LINES*DATA_WIDTH-1:0] sort_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_LINES*DATA_WIDTH-1:0] out_row,
    output logic                          busy
);

    localparam int DW = DATA_WIDTH;
    localparam int LW = N_LINES * DATA_WIDTH;

    state_t state;
    logic [2:0] row_cnt;
    logic [2:0] line_idx;
    logic [2:0] pass;

    logic [DW-1:0] m [LANES][LANES];
    tag_t tag_q [SORT_LAT];
    tag_t tag_out;

    logic col_pass;
    logic cap;
    logic cap_last;
    logic ld_we;
    logic [LANES-1:0] row_we;
    logic [LANES-1:0] col_we;
    logic [LW-1:0] mux_line;

    assign col_pass = pass[0];
    assign tag_out  = tag_q[SORT_LAT-1];
    assign cap      = tag_out.v;
    assign cap_last = cap && (tag_out.l == 3'd7);
    assign ld_we    = in_valid && in_ready;

    always_comb begin
        row_we = '0;
        col_we = '0;
        if (cap) begin
            if (col_pass) col_we[tag_out.l] = 1'b1;
            else          row_we[tag_out.l] = 1'b1;
        end
    end

    mdsa_line_mux #(.DW(DW)) u_mux (
        .m       (m),
        .col_sel (col_pass),
        .idx     (line_idx),
        .line    (mux_line)
    );

    // Combinational from the live matrix so a line issued right after
    // a write-back sees the updated data.
    assign sort_line = sort_en ? mux_line : '0;

    always_comb begin
        out_row = '0;
        for (int k = 0; k < LANES; k++) begin
            out_row[k*DW +: DW] = out_valid ? m[row_cnt][k] : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < LANES; r++) begin
            for (int c = 0; c < LANES; c++) begin
                if (ld_we && row_cnt == 3'(r))
                    m[r][c] <= in_row[c*DW +: DW];
                else if (row_we[r])
                    m[r][c] <= sort_result[c*DW +: DW];
                else if (col_we[c])
                    m[r][c] <= sort_result[r*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SORT_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{v: sort_en, l: line_idx};
            for (int i = 1; i < SORT_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            row_cnt   <= '0;
            line_idx  <= '0;
            pass      <= '0;
            in_ready  <= 1'b1;
            sort_en   <= 1'b0;
            sort_dir  <= DIR_ASC;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        busy    <= 1'b1;
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            state    <= ISSUE;
                            in_ready <= 1'b0;
                            pass     <= '0;
                            line_idx <= '0;
                            sort_en  <= 1'b1;
                            sort_dir <= DIR_ASC;
                        end
                    end
                end
                ISSUE: begin
                    if (line_idx == 3'd7) begin
                        state    <= DRAIN;
                        sort_en  <= 1'b0;
                        sort_dir <= DIR_ASC;
                    end else begin
                        line_idx <= line_idx + 3'd1;
                        // Row passes alternate direction to form the snake.
                        if (col_pass || line_idx[0])
                            sort_dir <= DIR_ASC;
                        else
                            sort_dir <= DIR_DESC;
                    end
                end
                DRAIN: begin
                    if (cap_last) begin
                        line_idx <= '0;
                        if (pass == 3'(PASSES-1)) begin
                            state     <= UNLOAD;
                            out_valid <= 1'b1;
                        end else begin
                            pass     <= pass + 3'd1;
                            state    <= ISSUE;
                            sort_en  <= 1'b1;
                            sort_dir <= DIR_ASC;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            pass      <= '0;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mdsa_shear_ctrl.sv
// Directed bench for mdsa_shear_ctrl with behavioural sorters at
// latency 1 (instance a) and latency 3 (instance b).
module tb_mdsa_shear_ctrl;

    localparam int DW = 32;
    localparam int LW = 8 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_sort_en, a_sort_dir;
    logic          a_out_valid, a_out_ready, a_busy;
    logic [LW-1:0] a_in_row, a_sort_line, a_sort_result, a_out_row;

    logic          b_in_valid, b_in_ready, b_sort_en, b_sort_dir;
    logic          b_out_valid, b_out_ready, b_busy;
    logic [LW-1:0] b_in_row, b_sort_line, b_sort_result, b_out_row;
    logic [LW-1:0] b_p1, b_p2;

    int n_pass = 0;
    int n_total = 0;

    mdsa_shear_ctrl #(.DATA_WIDTH(DW), .N_LINES(8), .SORT_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
        .sort_en(a_sort_en), .sort_dir(a_sort_dir),
        .sort_line(a_sort_line), .sort_result(a_sort_result),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_row(a_out_row), .busy(a_busy)
    );

    mdsa_shear_ctrl #(.DATA_WIDTH(DW), .N_LINES(8), .SORT_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
        .sort_en(b_sort_en), .sort_dir(b_sort_dir),
        .sort_line(b_sort_line), .sort_result(b_sort_result),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_row(b_out_row), .busy(b_busy)
    );

    function automatic logic [LW-1:0] sort8(input logic [LW-1:0] x,
                                            input logic d);
        logic [DW-1:0] v [8];
        logic [DW-1:0] t;
        logic [LW-1:0] r;
        for (int k = 0; k < 8; k++) v[k] = x[k*DW +: DW];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7; j++) begin
                if (d ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        r = '0;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = v[k];
        return r;
    endfunction

    always @(posedge clk) begin
        a_sort_result <= sort8(a_sort_line, a_sort_dir);
        b_p1 <= sort8(b_sort_line, b_sort_dir);
        b_p2 <= b_p1;
        b_sort_result <= b_p2;
    end

    function automatic logic [LW-1:0] mk_row(input int r, input int kind);
        logic [LW-1:0] x;
        int v;
        x = '0;
        for (int c = 0; c < 8; c++) begin
            if (kind == 0)      v = 63 - (8*r + c);
            else if (kind == 1) v = ((8*r + c) * 5) % 64;
            else                v = 5;
            x[c*DW +: DW] = DW'(v);
        end
        return x;
    endfunction

    function automatic logic [LW-1:0] exp_row(input int r, input int kind);
        logic [LW-1:0] x;
        int v;
        x = '0;
        for (int c = 0; c < 8; c++) begin
            if (kind == 2)      v = 5;
            else if (r % 2 == 1) v = 8*r + 7 - c;
            else                 v = 8*r + c;
            x[c*DW +: DW] = DW'(v);
        end
        return x;
    endfunction

    // Column 2 after pass 0 of the kind-0 matrix.
    function automatic logic [LW-1:0] col2_p0();
        logic [LW-1:0] x;
        x = '0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) x[k*DW +: DW] = DW'(58 - 8*k);
            else            x[k*DW +: DW] = DW'(61 - 8*k);
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int kind);
        for (int r = 0; r < 8; r++) begin
            a_in_valid = 1'b1;
            a_in_row = mk_row(r, kind);
            chk("a_load_ready", a_in_ready, 1);
            tick();
        end
        a_in_valid = 1'b0;
        a_in_row = '0;
    endtask

    task automatic wait_a(input int mode, output int cnt);
        cnt = 0;
        while (!a_out_valid && cnt < 400) begin
            if (mode == 1) begin
                if (cnt < 8) begin
                    chk("p0_sort_en", a_sort_en, 1);
                    chk("p0_sort_dir", a_sort_dir, cnt % 2);
                end
                if (cnt == 0) chk("p0_line0", a_sort_line, mk_row(0, 0));
                if (cnt == 11) begin
                    chk("p1_line2", a_sort_line, col2_p0());
                    chk("p1_dir", a_sort_dir, 0);
                end
            end
            if (mode == 2) begin
                a_in_valid = (cnt < 50);
                a_in_row = {8{32'hDEADBEEF}};
                if (cnt == 20) chk("issue_in_ready", a_in_ready, 0);
            end
            tick();
            cnt++;
        end
        a_in_valid = 1'b0;
        a_in_row = '0;
    endtask

    task automatic unload_a(input int kind, input int stall);
        if (stall != 0) begin
            a_out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
                chk("stall_valid", a_out_valid, 1);
                chk("stall_row0", a_out_row, exp_row(0, kind));
                chk("stall_in_ready", a_in_ready, 0);
                tick();
            end
        end
        a_out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            chk("a_out_valid", a_out_valid, 1);
            chk($sformatf("a_out_row%0d", r), a_out_row, exp_row(r, kind));
            tick();
        end
        a_out_ready = 1'b0;
        chk("a_end_in_ready", a_in_ready, 1);
        chk("a_end_busy", a_busy, 0);
        chk("a_end_out_valid", a_out_valid, 0);
    endtask

    initial begin
        int cnt;
        a_in_valid = 0; a_in_row = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_row = '0; b_out_ready = 0;
        repeat (2) tick();
        chk("rst_sort_en", a_sort_en, 0);
        chk("rst_sort_dir", a_sort_dir, 0);
        chk("rst_sort_line", a_sort_line, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", a_in_ready, 1);

        // Main sort with pass trace and output stall
        load_a(0);
        chk("busy_after_load", a_busy, 1);
        wait_a(1, cnt);
        chk("lat63_s1", cnt, 63);
        unload_a(0, 1);

        // Load beats during ISSUE are ignored
        load_a(0);
        wait_a(2, cnt);
        chk("lat63_s2", cnt, 63);
        unload_a(0, 0);

        // Reset during pass 3
        load_a(0);
        repeat (29) tick();
        chk("pre_rst_sort_en", a_sort_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sort_en", a_sort_en, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);
        chk("mid_rst_busy", a_busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", a_in_ready, 1);
        chk("post_rst_busy", a_busy, 0);
        load_a(1);
        wait_a(0, cnt);
        chk("lat63_s3", cnt, 63);
        unload_a(1, 0);

        // Latency-3 sorter, all elements equal
        for (int r = 0; r < 8; r++) begin
            b_in_valid = 1'b1;
            b_in_row = mk_row(r, 2);
            chk("b_load_ready", b_in_ready, 1);
            tick();
        end
        b_in_valid = 1'b0;
        cnt = 0;
        while (!b_out_valid && cnt < 400) begin
            if (cnt == 10) chk("b_drain_en", b_sort_en, 0);
            if (cnt == 11) chk("b_pass1_en", b_sort_en, 1);
            tick();
            cnt++;
        end
        chk("lat77", cnt, 77);
        b_out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            chk("b_out_valid", b_out_valid, 1);
            chk($sformatf("b_out_row%0d", r), b_out_row, exp_row(r, 2));
            tick();
        end
        b_out_ready = 1'b0;
        chk("b_end_in_ready", b_in_ready, 1);
        chk("b_end_busy", b_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
